// File: rtl/risc32_pkg.sv
// Shared debug-controller definitions: command op encodings, controller
// FSM states, the breakpoint register address and the step-count width.
package risc32_pkg;

  typedef enum logic [2:0] {
    OP_HALT    = 3'd0,
    OP_RUN     = 3'd1,
    OP_STEP    = 3'd2,
    OP_RD_REG  = 3'd3,
    OP_WR_REG  = 3'd4,
    OP_WR_IMEM = 3'd5,
    OP_WR_DMEM = 3'd6,
    OP_RD_PC   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_HALTED   = 3'd0,
    ST_RUNNING  = 3'd1,
    ST_STEPPING = 3'd2,
    ST_ACCESS   = 3'd3,
    ST_RESP     = 3'd4
  } dbg_state_e;

  // WR_REG to this index targets the breakpoint register when enabled
  localparam int unsigned BP_ADDR = 31;
  localparam int unsigned STEP_W  = 8;

endpackage

// File: rtl/debug_ctrl_if.sv
// Host command/response channel of the debug controller.
// slave: controller side, master: host side.
interface debug_ctrl_if #(
  parameter int unsigned MEM_AW = 5
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [MEM_AW-1:0] cmd_addr;
  logic [31:0]       cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/debug_step_counter.sv
// Step counter: loads N, decrements once per stepping cycle.
// done flags the final stepping cycle (count == 1).
module debug_step_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: load wins, otherwise decrement without wrapping below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/debug_ctrl.sv
// Debug controller: halts/runs/single-steps a core and gives the host
// access to its register file, instruction and data memories and PC.
// Optional feature macro: DEBUG_BREAKPOINT_EN (PC breakpoint via WR_REG 31).
module debug_ctrl
  import risc32_pkg::*;
#(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned MEM_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  debug_ctrl_if.slave       cmd_if,
  output logic              core_en,
  input  logic [31:0]       core_pc,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  input  logic [31:0]       reg_rdata,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata
);

  dbg_state_e        state_q, state_d;
  op_e               op_q, op_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              live_q, live_d;       // response shows the live (stopped) PC
  logic              ret_run_q, ret_run_d; // rejected op arrived while running
  logic              core_en_q, core_en_d;
  logic              init_q;

  logic              accept;
  logic              bp_hit;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_done;
  op_e               cmd_op_e;

  assign cmd_op_e = op_e'(cmd_if.cmd_op);

`ifdef DEBUG_BREAKPOINT_EN
  logic [31:0] bp_q, bp_d;
  logic        bp_en_q, bp_en_d;
  logic        addr_is_bp;

  assign addr_is_bp = (addr_q == MEM_AW'(BP_ADDR));
  assign bp_hit     = bp_en_q && (state_q == ST_RUNNING) && (core_pc == bp_q);

  // breakpoint register and enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_q    <= '0;
      bp_en_q <= 1'b0;
    end else begin
      bp_q    <= bp_d;
      bp_en_q <= bp_en_d;
    end
  end

  // breakpoint written from ACCESS of a WR_REG to the breakpoint index
  always_comb begin
    bp_d    = bp_q;
    bp_en_d = bp_en_q;
    if ((state_q == ST_ACCESS) && (op_q == OP_WR_REG) && addr_is_bp) begin
      bp_d    = data_q;
      bp_en_d = 1'b1;
    end
  end

  assign reg_we = (state_q == ST_ACCESS) && (op_q == OP_WR_REG) && !addr_is_bp;
`else
  assign bp_hit = 1'b0;
  assign reg_we = (state_q == ST_ACCESS) && (op_q == OP_WR_REG);
`endif

  assign cmd_if.cmd_ready = init_q && !bp_hit &&
                            ((state_q == ST_HALTED) || (state_q == ST_RUNNING));
  assign accept           = cmd_if.cmd_valid && cmd_if.cmd_ready;

  // a breakpoint stops the core in the very cycle the PC matches
  assign core_en   = core_en_q && !bp_hit;
  assign imem_we   = (state_q == ST_ACCESS) && (op_q == OP_WR_IMEM);
  assign dmem_we   = (state_q == ST_ACCESS) && (op_q == OP_WR_DMEM);
  assign reg_addr  = addr_q[REG_AW-1:0];
  assign reg_wdata = data_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;

  assign cmd_if.rsp_valid = (state_q == ST_RESP);
  assign cmd_if.rsp_err   = rsp_err_q;
  // after STEP the last instruction retires on the edge entering RESP, so the
  // stopped core's PC is passed through; it cannot change while core_en is 0
  assign cmd_if.rsp_data  = live_q ? core_pc : rsp_data_q;

  debug_step_counter #(.W(STEP_W)) u_step (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cmd_if.cmd_data[STEP_W-1:0]),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  // controller state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HALTED;
      op_q       <= OP_HALT;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      live_q     <= 1'b0;
      ret_run_q  <= 1'b0;
      core_en_q  <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      live_q     <= live_d;
      ret_run_q  <= ret_run_d;
      core_en_q  <= core_en_d;
      init_q     <= 1'b1;
    end
  end

  // next-state and response logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    live_d     = live_q;
    ret_run_d  = ret_run_q;
    core_en_d  = core_en_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    case (state_q)
      ST_HALTED: begin
        if (accept) begin
          op_d       = cmd_op_e;
          addr_d     = cmd_if.cmd_addr;
          data_d     = cmd_if.cmd_data;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          live_d     = 1'b0;
          ret_run_d  = 1'b0;
          case (cmd_op_e)
            OP_RUN: begin
              core_en_d = 1'b1;
              state_d   = ST_RUNNING;
            end
            OP_STEP: begin
              if (cmd_if.cmd_data[STEP_W-1:0] == '0) begin
                rsp_err_d = 1'b1;
                state_d   = ST_RESP;
              end else begin
                cnt_load  = 1'b1;
                core_en_d = 1'b1;
                state_d   = ST_STEPPING;
              end
            end
            default: state_d = ST_ACCESS;
          endcase
        end
      end

      ST_RUNNING: begin
        if (bp_hit) begin
          core_en_d  = 1'b0;
          rsp_data_d = core_pc;
          rsp_err_d  = 1'b0;
          live_d     = 1'b0;
          ret_run_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (accept) begin
          op_d   = cmd_op_e;
          live_d = 1'b0;
          if (cmd_op_e == OP_HALT) begin
            core_en_d = 1'b0;
            state_d   = ST_ACCESS;
          end else begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            ret_run_d  = 1'b1;
            state_d    = ST_RESP;
          end
        end
      end

      ST_STEPPING: begin
        cnt_dec = 1'b1;
        if (cnt_done) begin
          core_en_d = 1'b0;
          rsp_err_d = 1'b0;
          live_d    = 1'b1;
          state_d   = ST_RESP;
        end
      end

      ST_ACCESS: begin
        rsp_err_d = 1'b0;
        case (op_q)
          OP_RD_REG:         rsp_data_d = reg_rdata;
          OP_RD_PC, OP_HALT: rsp_data_d = core_pc;
          default:           rsp_data_d = '0;
        endcase
        state_d = ST_RESP;
      end

      ST_RESP: begin
        if (cmd_if.rsp_ready) begin
          state_d    = ret_run_q ? ST_RUNNING : ST_HALTED;
          ret_run_d  = 1'b0;
          live_d     = 1'b0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end

      default: state_d = ST_HALTED;
    endcase
  end

endmodule
